lfu_victim_sel: RTL and testbench

- Parametrised least-frequently-used replacement engine for an N-way set-associative cache.
- Holds a saturating use counter per way per set and updates it on hit/fill traffic from the cache controller.
- On request, scans one set sequentially and returns the victim way with the minimum count over a valid/ready handshake.
- Sits beside the tag array in the cache controller; successor to the fixed 4-way, purely combinational LFU compare.

---
 rtl/lfu_victim_sel.sv | 154 +++++++++++++++
 tb/tb_lfu_victim_sel.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfu_victim_sel.sv
// LFU victim selector: per-set saturating use counters plus a sequential min-scan over one set snapshot.
// Build option: define LFU_AGING_EN to halve a set's counters when a hit finds a counter at CMAX.
module lfu_victim_sel #(
    parameter  int unsigned WAYS  = 4,
    parameter  int unsigned CNT_W = 4,
    parameter  int unsigned SETS  = 16,
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_valid,
    input  logic             acc_fill,
    input  logic [SET_W-1:0] acc_set,
    input  logic [WAY_W-1:0] acc_way,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    output logic             vic_valid,
    input  logic             vic_ready,
    output logic [WAY_W-1:0] vic_way,
    output logic [CNT_W-1:0] vic_count
);

    localparam logic [CNT_W-1:0] CMAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WAY_W-1:0] LAST_IDX = WAY_W'(WAYS - 1);
`ifdef LFU_AGING_EN
    localparam logic [CNT_W-1:0] AGED_HIT = (CMAX >> 1) + CNT_ONE;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [CNT_W-1:0] r_cnt  [SETS][WAYS];
    logic [CNT_W-1:0] r_snap [WAYS];
    logic [CNT_W-1:0] r_min;
    logic [WAY_W-1:0] r_min_way;
    logic [WAY_W-1:0] r_idx;
    logic             r_req_ready;
    logic             r_vic_valid;
    state_t           r_state;

    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_req_ready_nxt;
    logic             w_vic_valid_nxt;
    logic [CNT_W-1:0] w_hit_cnt;
    logic [CNT_W-1:0] w_snap_idx;

    assign w_hit_cnt  = r_cnt[acc_set][acc_way];
    assign w_snap_idx = r_snap[r_idx];

    // Live use counters; only the addressed set changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    r_cnt[SET_W'(s)][WAY_W'(w)] <= '0;
                end
            end
        end else if (acc_valid) begin
            if (acc_fill) begin
                r_cnt[acc_set][acc_way] <= CNT_ONE;
            end else if (w_hit_cnt != CMAX) begin
                r_cnt[acc_set][acc_way] <= w_hit_cnt + CNT_ONE;
            end else begin
`ifdef LFU_AGING_EN
                for (int unsigned w = 0; w < WAYS; w++) begin
                    r_cnt[acc_set][WAY_W'(w)] <= r_cnt[acc_set][WAY_W'(w)] >> 1;
                end
                r_cnt[acc_set][acc_way] <= AGED_HIT;
`else
                r_cnt[acc_set][acc_way] <= CMAX;
`endif
            end
        end
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_vic_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_vic_valid <= w_vic_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_req_ready_nxt = 1'b0;
        w_vic_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (vic_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        w_vic_valid_nxt = (w_state_nxt == S_DONE);
    end

    // Snapshot on accept, then one strict-less-than compare per cycle so ties keep the lower way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                r_snap[WAY_W'(w)] <= '0;
            end
            r_min     <= '0;
            r_min_way <= '0;
            r_idx     <= '0;
        end else if (w_accept) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                r_snap[WAY_W'(w)] <= r_cnt[req_set][WAY_W'(w)];
            end
            r_min     <= r_cnt[req_set][0];
            r_min_way <= '0;
            r_idx     <= WAY_W'(1);
        end else if (r_state == S_SCAN) begin
            if (w_snap_idx < r_min) begin
                r_min     <= w_snap_idx;
                r_min_way <= r_idx;
            end
            r_idx <= r_idx + WAY_W'(1);
        end
    end

    assign req_ready = r_req_ready;
    assign vic_valid = r_vic_valid;
    assign vic_way   = r_min_way;
    assign vic_count = r_min;

endmodule

// File: tb/tb_lfu_victim_sel.sv
// Scoreboard bench for lfu_victim_sel: requests push expected victims, a negedge monitor pops on handshake.
module tb_lfu_victim_sel;

    localparam int unsigned WAYS  = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SETS  = 16;
    localparam int unsigned WAY_W = 2;
    localparam int unsigned SET_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             acc_valid;
    logic             acc_fill;
    logic [SET_W-1:0] acc_set;
    logic [WAY_W-1:0] acc_way;
    logic             req_valid;
    logic             req_ready;
    logic [SET_W-1:0] req_set;
    logic             vic_valid;
    logic             vic_ready;
    logic [WAY_W-1:0] vic_way;
    logic [CNT_W-1:0] vic_count;

    typedef struct packed {
        logic [WAY_W-1:0] way;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    lfu_victim_sel #(.WAYS(WAYS), .CNT_W(CNT_W), .SETS(SETS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_valid (acc_valid),
        .acc_fill  (acc_fill),
        .acc_set   (acc_set),
        .acc_way   (acc_way),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_set   (req_set),
        .vic_valid (vic_valid),
        .vic_ready (vic_ready),
        .vic_way   (vic_way),
        .vic_count (vic_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit fill, input int set, input int way, input int n);
        for (int i = 0; i < n; i++) begin
            acc_valid = 1'b1;
            acc_fill  = fill;
            acc_set   = SET_W'(set);
            acc_way   = WAY_W'(way);
            tick();
        end
        acc_valid = 1'b0;
        acc_fill  = 1'b0;
    endtask

    task automatic accept(input int set, input bit push, input int ew, input int ec);
        exp_t e;
        check("req_ready_idle", req_ready, 1);
        if (push) begin
            e.way = WAY_W'(ew);
            e.cnt = CNT_W'(ec);
            exp_q.push_back(e);
        end
        req_valid = 1'b1;
        req_set   = SET_W'(set);
        tick();
        req_valid = 1'b0;
    endtask

    // Waits for vic_valid with a cycle bound; checks latency and busy req_ready.
    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        while (vic_valid !== 1'b1 && cyc < 20) begin
            check({tag, "_req_ready_busy"}, req_ready, 0);
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, WAYS - 1);
        if (vic_ready) begin
            tick();
            check({tag, "_valid_drop"}, vic_valid, 0);
            check({tag, "_ready_back"}, req_ready, 1);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && vic_valid === 1'b1 && vic_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL vic_unexpected: way %0d count %0d with no pending request", vic_way, vic_count);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("vic_way", vic_way, e.way);
                    check("vic_count", vic_count, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n     = 1'b1;
        acc_valid = 1'b0;
        acc_fill  = 1'b0;
        acc_set   = '0;
        acc_way   = '0;
        req_valid = 1'b0;
        req_set   = '0;
        vic_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_vic_valid", vic_valid, 0);
        check("rst_vic_way", vic_way, 0);
        check("rst_vic_count", vic_count, 0);
        #2 rst_n = 1'b1;
        tick();

        // All-zero set: tie resolves to way 0.
        accept(0, 1'b1, 0, 0);
        wait_result("t1");

        // Set 2 counts 3,1,2,1 -> lowest-index minimum is way 1.
        access(1'b0, 2, 0, 3);
        access(1'b0, 2, 1, 1);
        access(1'b0, 2, 2, 2);
        access(1'b0, 2, 3, 1);
        accept(2, 1'b1, 1, 1);
        wait_result("t2");

        // Set 5: saturating hit on way 0.
        access(1'b1, 5, 3, 1);
        access(1'b0, 5, 0, 15);
        access(1'b0, 5, 1, 6);
        access(1'b0, 5, 2, 2);
        access(1'b0, 5, 0, 1);
`ifdef LFU_AGING_EN
        accept(5, 1'b1, 3, 0);
`else
        accept(5, 1'b1, 3, 1);
`endif
        wait_result("t3");

        // Backpressure in DONE while hits land on the scanned set.
        vic_ready = 1'b0;
        accept(2, 1'b1, 1, 1);
        wait_result("t4");
        for (int i = 0; i < 5; i++) begin
            acc_valid = 1'b1;
            acc_fill  = 1'b0;
            acc_set   = SET_W'(2);
            acc_way   = WAY_W'(1);
            check("hold_vic_valid", vic_valid, 1);
            check("hold_vic_way", vic_way, 1);
            check("hold_vic_count", vic_count, 1);
            check("hold_req_ready", req_ready, 0);
            tick();
        end
        acc_valid = 1'b0;
        vic_ready = 1'b1;
        tick();
        check("release_vic_valid", vic_valid, 0);
        check("release_req_ready", req_ready, 1);

        // Same-cycle accept and fill of set 1 way 0: snapshot sees the old 0.
        access(1'b0, 1, 1, 2);
        access(1'b0, 1, 2, 2);
        access(1'b0, 1, 3, 2);
        acc_valid = 1'b1;
        acc_fill  = 1'b1;
        acc_set   = SET_W'(1);
        acc_way   = WAY_W'(0);
        accept(1, 1'b1, 0, 0);
        acc_valid = 1'b0;
        acc_fill  = 1'b0;
        wait_result("t5");
        accept(1, 1'b1, 0, 1);
        wait_result("t5b");

        // Reset mid-scan drops the request and clears the counters.
        access(1'b0, 3, 0, 2);
        access(1'b0, 3, 1, 1);
        access(1'b0, 3, 2, 1);
        access(1'b0, 3, 3, 1);
        accept(3, 1'b0, 0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        check("midscan_rst_vic_valid", vic_valid, 0);
        check("midscan_rst_req_ready", req_ready, 1);
        check("midscan_rst_vic_way", vic_way, 0);
        #2 rst_n = 1'b1;
        tick();
        accept(3, 1'b1, 0, 0);
        wait_result("t6");

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
